bullet_scheduler: RTL

- Manages a fixed pool of player projectiles.
- Turns fire-key presses into slot allocations, enforces a per-shot cooldown, advances every live bullet once per frame, and retires bullets that reach the right screen edge.
- Sits between the keycode decoder and the colour mapper; replaces single-bullet handling with NUM_SLOTS independently scheduled bullets.

---
 rtl/bullet_pkg.sv | 9 +
 rtl/bullet_scheduler_if.sv | 21 ++
 rtl/bullet_slot.sv | 30 +++
 rtl/bullet_scheduler.sv | 89 ++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// bullet_pkg: shared constants, coordinate type and scheduler state enum
package bullet_pkg;
  typedef logic [9:0] coord_t;
  localparam logic [7:0] FIRE_KEY = 8'd44;
  localparam coord_t X_STEP = 10'd8;
  localparam coord_t X_MAX  = 10'd639;
  localparam coord_t B_SIZE = 10'd4;
  typedef enum logic {S_READY, S_COOLDOWN} state_t;
endpackage

// File: rtl/bullet_scheduler_if.sv
// bullet_scheduler_if: keyboard/player inputs and packed bullet outputs of the scheduler
interface bullet_scheduler_if
  import bullet_pkg::*;
#(
  parameter int NUM_SLOTS = 4
);
  logic [7:0] keycode;
  coord_t BallX, BallY, BallS;
  logic [10*NUM_SLOTS-1:0] BulletX, BulletY;
  coord_t BulletS;
  logic [NUM_SLOTS-1:0] slot_active;
  logic fire_ack, pool_full;
  modport master (
    output keycode, BallX, BallY, BallS,
    input  BulletX, BulletY, BulletS, slot_active, fire_ack, pool_full
  );
  modport slave (
    input  keycode, BallX, BallY, BallS,
    output BulletX, BulletY, BulletS, slot_active, fire_ack, pool_full
  );
endinterface

// File: rtl/bullet_slot.sv
// bullet_slot: one projectile's position/live registers with spawn load, per-frame advance and edge retire
module bullet_slot
  import bullet_pkg::*;
(
  input  logic   frame_clk,
  input  logic   Reset,
  input  logic   spawn,
  input  coord_t spawn_x,
  input  coord_t spawn_y,
  output coord_t x,
  output coord_t y,
  output logic   active
);
  logic retire;
  assign retire = ({1'b0, x} + {1'b0, X_STEP} + {1'b0, B_SIZE}) >= {1'b0, X_MAX};
  // spawn wins over motion; a retiring bullet freezes where it stopped
  always_ff @(posedge frame_clk or negedge Reset)
    if (!Reset) begin
      x <= '0;
      y <= '0;
      active <= 1'b0;
    end else if (spawn) begin
      x <= spawn_x;
      y <= spawn_y;
      active <= 1'b1;
    end else if (active) begin
      if (retire) active <= 1'b0;
      else x <= x + X_STEP;
    end
endmodule

// File: rtl/bullet_scheduler.sv
// bullet_scheduler: fire-key edge detect, cooldown FSM and round-robin slot allocator (BULLET_AUTOFIRE_EN: level-triggered fire)
module bullet_scheduler
  import bullet_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int COOLDOWN  = 8
) (
  input logic frame_clk,
  input logic Reset,
  bullet_scheduler_if.slave bus
);
  localparam int SW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = COOLDOWN > 1 ? $clog2(COOLDOWN) : 1;
`ifdef BULLET_AUTOFIRE_EN
  localparam bit AUTOFIRE = 1'b1;
`else
  localparam bit AUTOFIRE = 1'b0;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] rr, chosen, idx;
  logic [NUM_SLOTS-1:0] active, spawn;
  logic key_hit, key_prev, fire_req, found, ready, accept, fire_ack;
  coord_t spawn_x, spawn_y;
  assign key_hit  = bus.keycode == FIRE_KEY;
  assign fire_req = key_hit && (AUTOFIRE || !key_prev);
  // the counter's final frame also counts as ready so shots can be exactly COOLDOWN frames apart
  assign ready    = state == S_READY || cnt == '0;
  assign accept   = ready && fire_req && found;
  assign spawn_x  = bus.BallX + bus.BallS;
  assign spawn_y  = bus.BallY + bus.BallS;
  assign bus.slot_active = active;
  assign bus.pool_full   = &active;
  assign bus.fire_ack    = fire_ack;
  assign bus.BulletS     = B_SIZE;
  // first free slot at or after rr, wrapping; retiring slots still read as occupied
  always_comb begin
    found = 1'b0;
    chosen = rr;
    idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idx = SW'((int'(rr) + i) % NUM_SLOTS);
      if (!found && !active[idx]) begin
        found = 1'b1;
        chosen = idx;
      end
    end
  end
  // cooldown FSM next state: accepted shot reloads, otherwise count down to READY
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (accept) begin
      state_n = S_COOLDOWN;
      cnt_n = CW'(COOLDOWN - 1);
    end else if (state == S_COOLDOWN) begin
      state_n = cnt == '0 ? S_READY : S_COOLDOWN;
      cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
    end
  end
  // FSM, edge-detect history, allocator pointer and ack pulse
  always_ff @(posedge frame_clk or negedge Reset)
    if (!Reset) begin
      state <= S_READY;
      cnt <= '0;
      key_prev <= 1'b0;
      rr <= '0;
      fire_ack <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      key_prev <= key_hit;
      fire_ack <= accept;
      if (accept) rr <= chosen == SW'(NUM_SLOTS - 1) ? '0 : chosen + 1'b1;
    end
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    assign spawn[g] = accept && chosen == SW'(g);
    bullet_slot u_slot (
      .frame_clk(frame_clk),
      .Reset(Reset),
      .spawn(spawn[g]),
      .spawn_x(spawn_x),
      .spawn_y(spawn_y),
      .x(bus.BulletX[10*g +: 10]),
      .y(bus.BulletY[10*g +: 10]),
      .active(active[g])
    );
  end
endmodule
